// File: rtl/parity_fi_ctrl.sv
// -----------------------------------------------------------------------------
// parity_fi_ctrl
//
// Sequences the per-channel error-enable (ENERR) and fault-inject (FIERR)
// controls of the bus parity generator/checker, and folds the active-low
// parity error indications (ERR_B) into sticky flags, per-channel saturating
// counters and a single interrupt.
//
// A command/response handshake performs one operation at a time:
//   CMD_OP 00 ENABLE_SET  : ENERR[ch] <= 1, respond OK
//   CMD_OP 01 ENABLE_CLR  : ENERR[ch] <= 0, respond OK
//   CMD_OP 10 INJECT      : force FIERR[ch] until the next beat on the
//                           channel, then expect the checker to flag it
//   CMD_OP 11 / ch>=N_CH  : respond BAD_CMD
// RSP_STATUS: 00 OK/PASS, 01 NO_DETECT, 10 BAD_CMD, 11 NO_TRAFFIC
//
// Ports
//   ACLK, RESET_ACLK           clock, synchronous active-high reset
//   CMD_VALID/READY/OP/CH      command handshake
//   RSP_VALID/READY/STATUS     response handshake
//   CH_VALID[N_CH]             per-channel transfer beat
//   ERR_B[N_CH]                per-channel parity error, active-low
//   ENERR[N_CH], FIERR[N_CH]   controls to the parity block
//   STICKY_CLR[N_CH]           single-cycle clear of sticky flag and counter
//   STICKY_ERR[N_CH]           sticky functional error flags
//   ERR_CNT[8*N_CH]            saturating counts, channel i at [8i+7:8i]
//   IRQ                        registered OR of STICKY_ERR
//
// Build option
//   PARITY_FI_CTRL_ERR_CNT_EN  when defined the error counters are built;
//                              otherwise ERR_CNT is tied to zero.
// -----------------------------------------------------------------------------
module parity_fi_ctrl #(
    parameter int         N_CH      = 4,
    parameter int         TIMEOUT   = 64,
    parameter logic [3:0] ENERR_RST = 4'b1111
) (
    input  logic              ACLK,
    input  logic              RESET_ACLK,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [1:0]        CMD_OP,
    input  logic [1:0]        CMD_CH,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [1:0]        RSP_STATUS,
    input  logic [N_CH-1:0]   CH_VALID,
    input  logic [N_CH-1:0]   ERR_B,
    output logic [N_CH-1:0]   ENERR,
    output logic [N_CH-1:0]   FIERR,
    input  logic [N_CH-1:0]   STICKY_CLR,
    output logic [N_CH-1:0]   STICKY_ERR,
    output logic [8*N_CH-1:0] ERR_CNT,
    output logic              IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] OP_SET = 2'b00;
    localparam logic [1:0] OP_CLR = 2'b01;
    localparam logic [1:0] OP_INJ = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_NODET  = 2'b01;
    localparam logic [1:0] ST_BADCMD = 2'b10;
    localparam logic [1:0] ST_NOTRAF = 2'b11;

    // Counter only ever needs to reach TIMEOUT-1.
    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [1:0]          ch_q, ch_d;
    logic                saved_en_q, saved_en_d;
    logic [CW-1:0]       tmo_q, tmo_d;
    logic [1:0]          status_q, status_d;
    logic [N_CH-1:0]     enerr_q, enerr_d;
    logic [N_CH-1:0]     fierr_q, fierr_d;
    logic [N_CH-1:0]     sticky_q, sticky_d;
    logic                irq_q, irq_d;

    logic                cmd_ch_ok;
    logic                cmd_en_sel;
    logic                beat_sel;
    logic                err_sel;
    logic                inj_active;
    logic                inj_done;
    logic [N_CH-1:0]     err_cond;

    // Channel selects done by comparison rather than by variable index so the
    // 2-bit channel field stays legal for any N_CH, including out-of-range
    // values on CMD_CH.
    always_comb begin
        cmd_ch_ok  = (int'(CMD_CH) < N_CH);
        cmd_en_sel = 1'b0;
        beat_sel   = 1'b0;
        err_sel    = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(CMD_CH) == i) cmd_en_sel = enerr_q[i];
            if (int'(ch_q) == i) begin
                beat_sel = CH_VALID[i];
                err_sel  = ~ERR_B[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Command sequencer
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis would infer a latch.
        state_d    = state_q;
        ch_d       = ch_q;
        saved_en_d = saved_en_q;
        tmo_d      = tmo_q;
        status_d   = status_q;
        enerr_d    = enerr_q;
        fierr_d    = fierr_q;
        inj_done   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (CMD_VALID) begin
                    ch_d = CMD_CH;
                    if (!cmd_ch_ok || CMD_OP == OP_RSV) begin
                        status_d = ST_BADCMD;
                        state_d  = S_RESP;
                    end else if (CMD_OP == OP_INJ) begin
                        saved_en_d = cmd_en_sel;
                        for (int i = 0; i < N_CH; i++) begin
                            if (int'(CMD_CH) == i) begin
                                enerr_d[i] = 1'b1;
                                fierr_d[i] = 1'b1;
                            end
                        end
                        tmo_d   = '0;
                        state_d = S_ARM;
                    end else begin
                        for (int i = 0; i < N_CH; i++) begin
                            if (int'(CMD_CH) == i) enerr_d[i] = (CMD_OP == OP_SET);
                        end
                        status_d = ST_OK;
                        state_d  = S_RESP;
                    end
                end
            end

            S_ARM: begin
                tmo_d = tmo_q + CW'(1);
                if (beat_sel) begin
                    // The corrupted beat has gone out; stop injecting and
                    // restart the timer for the detection window.
                    for (int i = 0; i < N_CH; i++) begin
                        if (int'(ch_q) == i) fierr_d[i] = 1'b0;
                    end
                    tmo_d = '0;
                    if (err_sel) begin
                        status_d = ST_OK;
                        inj_done = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    status_d = ST_NOTRAF;
                    inj_done = 1'b1;
                end
            end

            S_WAIT: begin
                tmo_d = tmo_q + CW'(1);
                // Detection is tested first so it wins over a same-cycle
                // timeout.
                if (err_sel) begin
                    status_d = ST_OK;
                    inj_done = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    status_d = ST_NODET;
                    inj_done = 1'b1;
                end
            end

            S_RESP: begin
                if (RSP_READY) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // Common exit from an injection: put the channel's enable back the
        // way the user left it and make sure injection is off.
        if (inj_done) begin
            state_d = S_RESP;
            for (int i = 0; i < N_CH; i++) begin
                if (int'(ch_q) == i) begin
                    enerr_d[i] = saved_en_q;
                    fierr_d[i] = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Functional error monitor
    // ------------------------------------------------------------------
    assign inj_active = (state_q == S_ARM) || (state_q == S_WAIT);

    always_comb begin
        err_cond = '0;
        sticky_d = sticky_q;
        for (int i = 0; i < N_CH; i++) begin
            // The channel under self-test is expected to error; that is not
            // a functional fault.
            err_cond[i] = ~ERR_B[i] & ~(inj_active && int'(ch_q) == i);
            if (err_cond[i])        sticky_d[i] = 1'b1;
            else if (STICKY_CLR[i]) sticky_d[i] = 1'b0;
        end
        irq_d = |sticky_q;
    end

    always_ff @(posedge ACLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (RESET_ACLK) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            saved_en_q <= 1'b0;
            tmo_q      <= '0;
            status_q   <= ST_OK;
            enerr_q    <= ENERR_RST[N_CH-1:0];
            fierr_q    <= '0;
            sticky_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            saved_en_q <= saved_en_d;
            tmo_q      <= tmo_d;
            status_q   <= status_d;
            enerr_q    <= enerr_d;
            fierr_q    <= fierr_d;
            sticky_q   <= sticky_d;
            irq_q      <= irq_d;
        end
    end

`ifdef PARITY_FI_CTRL_ERR_CNT_EN
    logic [8*N_CH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < N_CH; i++) begin
            if (err_cond[i]) begin
                // A clear coincident with an error restarts the count at one.
                if (STICKY_CLR[i])
                    cnt_d[8*i +: 8] = 8'd1;
                else if (cnt_q[8*i +: 8] != 8'hFF)
                    cnt_d[8*i +: 8] = cnt_q[8*i +: 8] + 8'd1;
            end else if (STICKY_CLR[i]) begin
                cnt_d[8*i +: 8] = 8'd0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (RESET_ACLK) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    assign ERR_CNT = cnt_q;
`else
    assign ERR_CNT = '0;
`endif

    assign CMD_READY  = (state_q == S_IDLE);
    assign RSP_VALID  = (state_q == S_RESP);
    assign RSP_STATUS = status_q;
    assign ENERR      = enerr_q;
    assign FIERR      = fierr_q;
    assign STICKY_ERR = sticky_q;
    assign IRQ        = irq_q;

endmodule

// File: tb/tb_parity_fi_ctrl.sv
// -----------------------------------------------------------------------------
// tb_parity_fi_ctrl
//
// Self-checking bench for parity_fi_ctrl: a command vector table, hand-written
// injection / saturation / reset sequences, and a randomized error phase
// checked against a simple per-channel model. A second instance with N_CH=3
// covers the out-of-range channel case.
// -----------------------------------------------------------------------------
module tb_parity_fi_ctrl;

`ifdef PARITY_FI_CTRL_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [1:0] OP_SET = 2'b00;
    localparam logic [1:0] OP_CLR = 2'b01;
    localparam logic [1:0] OP_INJ = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op, cmd_ch;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_status;
    logic [3:0]  ch_valid, err_b, enerr, fierr, sticky_clr, sticky_err;
    logic [31:0] err_cnt;
    logic        irq;

    parity_fi_ctrl #(.N_CH(4), .TIMEOUT(64), .ENERR_RST(4'b1111)) dut (
        .ACLK(clk), .RESET_ACLK(rst),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
        .CMD_OP(cmd_op), .CMD_CH(cmd_ch),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_STATUS(rsp_status),
        .CH_VALID(ch_valid), .ERR_B(err_b),
        .ENERR(enerr), .FIERR(fierr),
        .STICKY_CLR(sticky_clr), .STICKY_ERR(sticky_err),
        .ERR_CNT(err_cnt), .IRQ(irq)
    );

    // Three-channel instance
    logic        c3_cmd_valid, c3_cmd_ready;
    logic [1:0]  c3_cmd_op, c3_cmd_ch;
    logic        c3_rsp_valid;
    logic        c3_rsp_ready;
    logic [1:0]  c3_rsp_status;
    logic [2:0]  c3_ch_valid, c3_err_b, c3_enerr, c3_fierr, c3_sticky_clr, c3_sticky_err;
    logic [23:0] c3_err_cnt;
    logic        c3_irq;

    parity_fi_ctrl #(.N_CH(3), .TIMEOUT(64), .ENERR_RST(4'b1111)) dut3 (
        .ACLK(clk), .RESET_ACLK(rst),
        .CMD_VALID(c3_cmd_valid), .CMD_READY(c3_cmd_ready),
        .CMD_OP(c3_cmd_op), .CMD_CH(c3_cmd_ch),
        .RSP_VALID(c3_rsp_valid), .RSP_READY(c3_rsp_ready), .RSP_STATUS(c3_rsp_status),
        .CH_VALID(c3_ch_valid), .ERR_B(c3_err_b),
        .ENERR(c3_enerr), .FIERR(c3_fierr),
        .STICKY_CLR(c3_sticky_clr), .STICKY_ERR(c3_sticky_err),
        .ERR_CNT(c3_err_cnt), .IRQ(c3_irq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int cycles);
        cycles = 0;
        while (!rsp_valid && cycles < 500) begin
            step();
            cycles++;
        end
        if (!rsp_valid) check("rsp_wait_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [1:0] ch);
        check("cmd_ready_before_send", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ch    = ch;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic do_cmd(input string name, input logic [1:0] op, input logic [1:0] ch,
                          input logic [1:0] exp_st, input logic [3:0] exp_en);
        int c;
        send_cmd(op, ch);
        wait_rsp(c);
        check({name, "_status"}, rsp_status, exp_st);
        step();
        check({name, "_enerr"}, enerr, exp_en);
        check({name, "_fierr"}, fierr, 4'b0000);
    endtask

    // ---------------- reference model for the error monitor -----------------
    int m_cnt[4];
    bit m_st[4];
    bit m_irq;

    task automatic model_edge(input logic [3:0] eb, input logic [3:0] cl, input int excl);
        bit any;
        any = 1'b0;
        for (int i = 0; i < 4; i++) any |= m_st[i];
        for (int i = 0; i < 4; i++) begin
            if (!eb[i] && i != excl) begin
                m_st[i]  = 1'b1;
                m_cnt[i] = cl[i] ? 1 : ((m_cnt[i] + 1 > 255) ? 255 : m_cnt[i] + 1);
            end else if (cl[i]) begin
                m_st[i]  = 1'b0;
                m_cnt[i] = 0;
            end
        end
        m_irq = any;
    endtask

    task automatic model_compare();
        logic [3:0]  exp_st;
        logic [31:0] exp_cnt;
        for (int i = 0; i < 4; i++) begin
            exp_st[i]         = m_st[i];
            exp_cnt[8*i +: 8] = CNT_EN ? 8'(m_cnt[i]) : 8'd0;
        end
        check("rand_sticky", sticky_err, exp_st);
        check("rand_err_cnt", err_cnt, exp_cnt);
        check("rand_irq", irq, m_irq);
    endtask

    task automatic rand_cycle(input int excl);
        logic [3:0] eb, cl;
        for (int i = 0; i < 4; i++) begin
            eb[i] = ($urandom_range(3) != 0);
            cl[i] = ($urandom_range(7) == 0);
        end
        err_b      = eb;
        sticky_clr = cl;
        step();
        model_edge(eb, cl, excl);
        model_compare();
    endtask

    // ---------------- command vector table ----------------------------------
    typedef struct {
        logic [1:0] op;
        logic [1:0] ch;
        logic [1:0] exp_st;
        logic [3:0] exp_en;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c;
        int fierr_cycles;
        bit hold_ok;

        vecs[0] = '{OP_CLR, 2'd1, 2'b00, 4'b1101};
        vecs[1] = '{OP_SET, 2'd1, 2'b00, 4'b1111};
        vecs[2] = '{OP_CLR, 2'd0, 2'b00, 4'b1110};
        vecs[3] = '{OP_CLR, 2'd3, 2'b00, 4'b0110};
        vecs[4] = '{OP_RSV, 2'd2, 2'b10, 4'b0110};
        vecs[5] = '{OP_SET, 2'd0, 2'b00, 4'b0111};
        vecs[6] = '{OP_SET, 2'd3, 2'b00, 4'b1111};
        vecs[7] = '{OP_RSV, 2'd0, 2'b10, 4'b1111};

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_ch = 2'b00;
        rsp_ready = 1'b1; ch_valid = 4'b0000; err_b = 4'b1111; sticky_clr = 4'b0000;
        c3_cmd_valid = 1'b0; c3_cmd_op = 2'b00; c3_cmd_ch = 2'b00; c3_rsp_ready = 1'b1;
        c3_ch_valid = 3'b000; c3_err_b = 3'b111; c3_sticky_clr = 3'b000;

        // ---------------- reset state ----------------
        step(); step();
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_status", rsp_status, 2'b00);
        check("rst_enerr", enerr, 4'b1111);
        check("rst_fierr", fierr, 4'b0000);
        check("rst_sticky", sticky_err, 4'b0000);
        check("rst_err_cnt", err_cnt, 32'd0);
        check("rst_irq", irq, 1'b0);
        rst = 1'b0;
        step();

        // ---------------- enable set/clear and bad commands ----------------
        for (int v = 0; v < 8; v++)
            do_cmd($sformatf("vec%0d", v), vecs[v].op, vecs[v].ch, vecs[v].exp_st, vecs[v].exp_en);

        // ---------------- INJECT ch0: beat at ARM cycle 5, detect 2 later ----
        send_cmd(OP_INJ, 2'd0);
        fierr_cycles = 0;
        for (int k = 0; k < 6; k++) begin
            if (fierr[0]) fierr_cycles++;
            if (k == 5) ch_valid[0] = 1'b1;
            step();
        end
        ch_valid = 4'b0000;
        if (fierr[0]) fierr_cycles++;
        step();
        if (fierr[0]) fierr_cycles++;
        err_b[0] = 1'b0;
        step();
        err_b = 4'b1111;
        if (fierr[0]) fierr_cycles++;
        check("inj0_fierr_cycles", fierr_cycles, 6);
        check("inj0_rsp_valid", rsp_valid, 1'b1);
        check("inj0_status", rsp_status, 2'b00);
        step();
        check("inj0_sticky", sticky_err, 4'b0000);
        check("inj0_err_cnt", err_cnt, 32'd0);
        check("inj0_enerr", enerr, 4'b1111);
        check("inj0_irq", irq, 1'b0);

        // ---------------- INJECT ch2, no traffic, ENERR[2] initially 0 -------
        do_cmd("clr2", OP_CLR, 2'd2, 2'b00, 4'b1011);
        send_cmd(OP_INJ, 2'd2);
        check("inj2_enerr_during", enerr, 4'b1111);
        check("inj2_fierr_during", fierr, 4'b0100);
        wait_rsp(c);
        check("inj2_arm_cycles", c, 64);
        check("inj2_status", rsp_status, 2'b11);
        step();
        check("inj2_enerr_after", enerr, 4'b1011);
        check("inj2_fierr_after", fierr, 4'b0000);
        do_cmd("set2", OP_SET, 2'd2, 2'b00, 4'b1111);

        // ---------------- INJECT ch3, beat, no detect, response held ---------
        send_cmd(OP_INJ, 2'd3);
        ch_valid[3] = 1'b1;
        step();
        ch_valid  = 4'b0000;
        rsp_ready = 1'b0;
        check("inj3_fierr_after_beat", fierr, 4'b0000);
        wait_rsp(c);
        check("inj3_wait_cycles", c, 64);
        check("inj3_status", rsp_status, 2'b01);
        hold_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (!(rsp_valid === 1'b1 && rsp_status === 2'b01 && cmd_ready === 1'b0))
                hold_ok = 1'b0;
        end
        check("inj3_rsp_hold", hold_ok, 1'b1);
        rsp_ready = 1'b1;
        step();
        check("inj3_cmd_ready_after", cmd_ready, 1'b1);
        check("inj3_rsp_valid_after", rsp_valid, 1'b0);
        check("inj3_enerr_after", enerr, 4'b1111);

        // ---------------- ERR_B[1] low 300 cycles: saturation ----------------
        err_b[1] = 1'b0;
        step();
        check("sat_sticky_first", sticky_err, 4'b0010);
        check("sat_irq_lag", irq, 1'b0);
        step();
        check("sat_irq_set", irq, 1'b1);
        for (int k = 0; k < 298; k++) step();
        check("sat_err_cnt", err_cnt, CNT_EN ? 32'h0000_FF00 : 32'd0);
        check("sat_sticky", sticky_err, 4'b0010);
        sticky_clr[1] = 1'b1;
        step();
        check("clr_with_err_cnt", err_cnt, CNT_EN ? 32'h0000_0100 : 32'd0);
        check("clr_with_err_sticky", sticky_err, 4'b0010);
        err_b = 4'b1111;
        step();
        sticky_clr = 4'b0000;
        check("clr_alone_sticky", sticky_err, 4'b0000);
        check("clr_alone_cnt", err_cnt, 32'd0);
        step();
        check("clr_irq_drop", irq, 1'b0);

        // ---------------- randomized monitor, idle and during injection ------
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_st[i]  = 1'b0;
        end
        m_irq = 1'b0;
        for (int k = 0; k < 300; k++) rand_cycle(-1);
        err_b = 4'b1111; sticky_clr = 4'b0000;
        send_cmd(OP_INJ, 2'd0);
        model_edge(4'b1111, 4'b0000, -1);
        for (int k = 0; k < 64; k++) rand_cycle(0);
        check("rand_inj_rsp_valid", rsp_valid, 1'b1);
        check("rand_inj_status", rsp_status, 2'b11);
        for (int k = 0; k < 100; k++) rand_cycle(-1);
        err_b = 4'b1111;
        sticky_clr = 4'b1111;
        step();
        sticky_clr = 4'b0000;
        step();

        // ---------------- three-channel instance: out-of-range channel -------
        c3_cmd_valid = 1'b1; c3_cmd_op = OP_SET; c3_cmd_ch = 2'd3;
        step();
        c3_cmd_valid = 1'b0;
        check("c3_bad_rsp_valid", c3_rsp_valid, 1'b1);
        check("c3_bad_status", c3_rsp_status, 2'b10);
        step();
        check("c3_bad_enerr", c3_enerr, 3'b111);
        check("c3_bad_fierr", c3_fierr, 3'b000);
        c3_cmd_valid = 1'b1; c3_cmd_op = OP_CLR; c3_cmd_ch = 2'd2;
        step();
        c3_cmd_valid = 1'b0;
        check("c3_clr2_status", c3_rsp_status, 2'b00);
        step();
        check("c3_clr2_enerr", c3_enerr, 3'b011);

        // ---------------- reset during ARM ----------------
        send_cmd(OP_INJ, 2'd0);
        step(); step();
        check("arm_fierr_before_rst", fierr, 4'b0001);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_arm_fierr", fierr, 4'b0000);
        check("rst_arm_cmd_ready", cmd_ready, 1'b1);

        // ---------------- reset during WAIT (ENERR[2] saved as 0) ----------
        do_cmd("clr2b", OP_CLR, 2'd2, 2'b00, 4'b1011);
        send_cmd(OP_INJ, 2'd2);
        ch_valid[2] = 1'b1;
        step();
        ch_valid = 4'b0000;
        step();
        check("wait_enerr_before_rst", enerr, 4'b1111);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_wait_fierr", fierr, 4'b0000);
        check("rst_wait_enerr", enerr, 4'b1111);
        check("rst_wait_rsp_valid", rsp_valid, 1'b0);
        check("rst_wait_cmd_ready", cmd_ready, 1'b1);
        step(); step();
        check("rst_wait_no_rsp_later", rsp_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
